br_channel_controller: RTL
==========================

BR_CHANNEL_CONTROLLER -- requirements
Module: br_channel_controller

Interface
REQ-001 Parameter Slaves_Num, default 2: number of upstream (S) ports.
REQ-002 Parameter Slaves_ID_Size, default $clog2(Slaves_Num) = 1: width of the master ID.
REQ-003 Parameter Resp_Fifo_Depth, default 4: order-FIFO depth per downstream (M) port, a power of 2.
REQ-004 ACLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 ARESET  in  1  reset, asynchronous assert, active-high.
REQ-006 Write_Data_Master  in  Slaves_ID_Size  S-port ID whose W burst completed on M00.
REQ-007 Write_Data_Finsh  in  1  one-cycle pulse: W burst on M00 completed.
REQ-008 Write_Data_Master2  in  Slaves_ID_Size  S-port ID whose W burst completed on M01.
REQ-009 Write_Data_Finsh2  in  1  one-cycle pulse: W burst on M01 completed.
REQ-010 M00_AXI_bresp / M01_AXI_bresp  in  2  downstream write response.
REQ-011 M00_AXI_bvalid / M01_AXI_bvalid  in  1  downstream response valid.
REQ-012 M00_AXI_bready / M01_AXI_bready  out  1  downstream response ready.
REQ-013 S00_AXI_bresp / S01_AXI_bresp  out  2  upstream write response, registered.
REQ-014 S00_AXI_bvalid / S01_AXI_bvalid  out  1  upstream response valid, registered.
REQ-015 S00_AXI_bready / S01_AXI_bready  in  1  upstream response ready.
REQ-016 Resp_Queue_Full  out  1  combinational; high when any order FIFO holds Resp_Fifo_Depth entries.

Function
REQ-017 Each M port k shall own an order FIFO; a Finsh pulse for port k pushes the matching Write_Data_Master ID.
REQ-018 The head of FIFO k shall name the target S port for M_k's next response; an empty FIFO means no target.
REQ-019 Each S port shall hold one response register: valid bit plus 2-bit bresp, driving S_bvalid/S_bresp directly.
REQ-020 M_k_bready shall equal: FIFO k non-empty AND target S register empty AND M_k granted for that target; it is combinational.
REQ-021 Arbitration: when both M ports are eligible for the same S port in the same cycle, the per-S-port round-robin pointer picks the winner; the pointer toggles only after a grant made under contention.
REQ-022 On an M_k handshake (bvalid & bready) in cycle N: pop FIFO k and load the target S register with bresp; S_bvalid rises in cycle N+1 (latency 1).
REQ-023 The S register shall clear on an S handshake (bvalid & bready); it shall not reload in that same cycle, so each S port sustains at most one response per 2 cycles.
REQ-024 S_bresp and S_bvalid shall stay stable while S_bvalid=1 and S_bready=0.
REQ-025 M_k_bvalid with FIFO k empty: M_k_bready stays 0 and the response is held off; no error is generated.
REQ-026 Push into a full FIFO without a simultaneous pop: the push is dropped and the count is unchanged; Resp_Queue_Full is already high to stall upstream AW grants.
REQ-027 Simultaneous push and pop on the same FIFO, including when full: both take effect and the count is unchanged.
REQ-028 FIFO pointers shall wrap modulo Resp_Fifo_Depth; the count width is $clog2(Resp_Fifo_Depth)+1.
REQ-029 The two M ports targeting different S ports shall complete in the same cycle independently.

Reset
REQ-030 While ARESET=1: all FIFOs empty, S00/S01_AXI_bvalid=0, S00/S01_AXI_bresp=2'b00, M00/M01_AXI_bready=0, Resp_Queue_Full=0, round-robin pointers prefer M00.
REQ-031 ARESET asserted mid-transaction shall discard queued IDs and held responses immediately, without waiting for a clock edge.
REQ-032 The first push is accepted on the first rising edge after ARESET deasserts.

Verification
REQ-033 Pulse Finsh with ID=1, then M00 bvalid with bresp=2'b10 -> M00_bready=1 that cycle; next cycle S01_bvalid=1, bresp=2'b10; S00_bvalid stays 0.
REQ-034 Both FIFO heads target S0, both M bvalid with bresp 00 and 01 -> M00 served first; M01 served once the S0 register drains; the following contention goes to M01.
REQ-035 Five Finsh pulses on M00 with no responses -> Resp_Queue_Full=1 after the 4th; the 5th is dropped; four responses then drain in push order.
REQ-036 Hold S00_bready=0 for 3 cycles with S00_bvalid=1 -> bresp is stable and M bready stays 0 for a second S0-targeted response.
REQ-037 M01 bvalid=1 with FIFO 1 empty for 5 cycles -> M01_bready=0 throughout; no S output changes.
REQ-038 Assert ARESET while S01_bvalid=1 and FIFOs are non-empty -> S01_bvalid=0 without a clock edge; after release, M bvalid gets no bready until a new Finsh pulse.

Source files
------------

// File: rtl/br_channel_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : br_channel_controller_if
// Purpose  : Bundles the W-completion events, the two downstream (M) write
//            response channels, the two upstream (S) write response channels
//            and the queue-full flag of br_channel_controller.
//            master : environment side (drives events, M responses, S ready)
//            slave  : controller side
// Revision : 1.0 - initial release
// ============================================================================
interface br_channel_controller_if #(
  parameter int Slaves_ID_Size = 1
);
  logic [Slaves_ID_Size-1:0] Write_Data_Master;
  logic                      Write_Data_Finsh;
  logic [Slaves_ID_Size-1:0] Write_Data_Master2;
  logic                      Write_Data_Finsh2;

  logic [1:0]                M00_AXI_bresp;
  logic                      M00_AXI_bvalid;
  logic                      M00_AXI_bready;
  logic [1:0]                M01_AXI_bresp;
  logic                      M01_AXI_bvalid;
  logic                      M01_AXI_bready;

  logic [1:0]                S00_AXI_bresp;
  logic                      S00_AXI_bvalid;
  logic                      S00_AXI_bready;
  logic [1:0]                S01_AXI_bresp;
  logic                      S01_AXI_bvalid;
  logic                      S01_AXI_bready;

  logic                      Resp_Queue_Full;

  modport master (
    output Write_Data_Master, Write_Data_Finsh,
    output Write_Data_Master2, Write_Data_Finsh2,
    output M00_AXI_bresp, M00_AXI_bvalid,
    output M01_AXI_bresp, M01_AXI_bvalid,
    output S00_AXI_bready, S01_AXI_bready,
    input  M00_AXI_bready, M01_AXI_bready,
    input  S00_AXI_bresp, S00_AXI_bvalid,
    input  S01_AXI_bresp, S01_AXI_bvalid,
    input  Resp_Queue_Full
  );

  modport slave (
    input  Write_Data_Master, Write_Data_Finsh,
    input  Write_Data_Master2, Write_Data_Finsh2,
    input  M00_AXI_bresp, M00_AXI_bvalid,
    input  M01_AXI_bresp, M01_AXI_bvalid,
    input  S00_AXI_bready, S01_AXI_bready,
    output M00_AXI_bready, M01_AXI_bready,
    output S00_AXI_bresp, S00_AXI_bvalid,
    output S01_AXI_bresp, S01_AXI_bvalid,
    output Resp_Queue_Full
  );
endinterface
`default_nettype wire

// File: rtl/br_channel_controller.sv
`default_nettype none
// ============================================================================
// Module   : br_channel_controller
// Purpose  : Routes AXI write responses from two downstream (M) ports back to
//            two upstream (S) ports. Each M port keeps an order FIFO of the S
//            IDs whose W bursts it completed; the FIFO head selects where the
//            next B response goes. Each S port has a one-entry response
//            register; contention for the same S port is settled by a
//            per-S-port round-robin pointer.
// Revision : 1.0 - initial release
// ============================================================================
module br_channel_controller #(
  parameter int Slaves_Num      = 2,
  parameter int Slaves_ID_Size  = $clog2(Slaves_Num),
  parameter int Resp_Fifo_Depth = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  br_channel_controller_if.slave bus
);

  localparam int PTR_W       = $clog2(Resp_Fifo_Depth);
  localparam int CNT_W       = PTR_W + 1;
  // Only two physical S ports exist; IDs beyond them never get a target.
  localparam int NUM_S_PORTS = (Slaves_Num < 2) ? Slaves_Num : 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(Resp_Fifo_Depth);

  // Per-M-port views of the interface (index 0 = M00, 1 = M01)
  logic [1:0]                push_w;
  logic [Slaves_ID_Size-1:0] push_id_w [2];
  logic [1:0]                m_bvalid_w;
  logic [1:0]                m_bresp_w [2];
  logic [1:0]                m_bready_w;
  logic [1:0]                m_hs_w;

  // Order FIFO status
  logic                      fifo_nempty_w [2];
  logic                      fifo_full_w   [2];
  logic [Slaves_ID_Size-1:0] head_w        [2];

  // Routing / arbitration
  logic [1:0]                tgt_w;
  logic [1:0]                elig_w;
  logic                      contend_w;

  // S-port response registers (index 0 = S00, 1 = S01)
  logic [1:0]                s_bready_w;
  logic [1:0]                s_hs_w;
  logic [1:0]                s_valid_q, s_valid_d;
  logic [1:0]                s_resp_q [2];
  logic [1:0]                s_resp_d [2];
  // Round-robin pointer per S port: 0 prefers M00, 1 prefers M01
  logic [1:0]                rr_q, rr_d;

  assign push_w       = {bus.Write_Data_Finsh2, bus.Write_Data_Finsh};
  assign push_id_w[0] = bus.Write_Data_Master;
  assign push_id_w[1] = bus.Write_Data_Master2;
  assign m_bvalid_w   = {bus.M01_AXI_bvalid, bus.M00_AXI_bvalid};
  assign m_bresp_w[0] = bus.M00_AXI_bresp;
  assign m_bresp_w[1] = bus.M01_AXI_bresp;
  assign s_bready_w   = {bus.S01_AXI_bready, bus.S00_AXI_bready};

  assign bus.M00_AXI_bready  = m_bready_w[0];
  assign bus.M01_AXI_bready  = m_bready_w[1];
  assign bus.S00_AXI_bvalid  = s_valid_q[0];
  assign bus.S00_AXI_bresp   = s_resp_q[0];
  assign bus.S01_AXI_bvalid  = s_valid_q[1];
  assign bus.S01_AXI_bresp   = s_resp_q[1];
  assign bus.Resp_Queue_Full = fifo_full_w[0] | fifo_full_w[1];

  assign m_hs_w = m_bvalid_w & m_bready_w;
  assign s_hs_w = s_valid_q & s_bready_w;

  generate
    for (genvar k = 0; k < 2; k++) begin : g_fifo
      logic [Slaves_ID_Size-1:0] mem_q [Resp_Fifo_Depth];
      logic [PTR_W-1:0]          wr_q, wr_d;
      logic [PTR_W-1:0]          rd_q, rd_d;
      logic [CNT_W-1:0]          cnt_q, cnt_d;
      logic                      pop_w;
      logic                      do_push_w;

      assign pop_w            = m_hs_w[k];
      // A full FIFO still accepts a push when a pop frees a slot that cycle
      assign do_push_w        = push_w[k] && (!fifo_full_w[k] || pop_w);
      assign fifo_full_w[k]   = (cnt_q == FULL_CNT);
      assign fifo_nempty_w[k] = (cnt_q != '0);
      assign head_w[k]        = mem_q[rd_q];

      // Next pointers and occupancy; pointers wrap naturally at the depth
      always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push_w) wr_d = wr_q + 1'b1;
        if (pop_w)     rd_d = rd_q + 1'b1;
        cnt_d = cnt_q + CNT_W'(do_push_w) - CNT_W'(pop_w);
      end

      // FIFO pointer/count registers, cleared asynchronously
      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
          wr_q  <= '0;
          rd_q  <= '0;
          cnt_q <= '0;
        end else begin
          wr_q  <= wr_d;
          rd_q  <= rd_d;
          cnt_q <= cnt_d;
        end
      end

      // ID storage; contents are meaningless while the count is zero
      always_ff @(posedge ACLK) begin
        if (do_push_w) mem_q[wr_q] <= push_id_w[k];
      end
    end
  endgenerate

  // Eligibility, contention and combinational M-side ready
  always_comb begin
    tgt_w      = '0;
    elig_w     = '0;
    contend_w  = 1'b0;
    m_bready_w = '0;
    for (int k = 0; k < 2; k++) begin
      tgt_w[k]  = head_w[k][0];
      elig_w[k] = fifo_nempty_w[k] && (32'(head_w[k]) < NUM_S_PORTS) &&
                  !s_valid_q[tgt_w[k]];
    end
    contend_w     = elig_w[0] && elig_w[1] && (tgt_w[0] == tgt_w[1]);
    m_bready_w[0] = elig_w[0] && (!contend_w || !rr_q[tgt_w[0]]);
    m_bready_w[1] = elig_w[1] && (!contend_w ||  rr_q[tgt_w[1]]);
  end

  // S register next state: drain on S handshake, load on M handshake.
  // A load only happens into an empty register, so the two never collide.
  always_comb begin
    s_valid_d = s_valid_q;
    s_resp_d  = s_resp_q;
    rr_d      = rr_q;
    for (int s = 0; s < 2; s++) begin
      if (s_hs_w[s]) s_valid_d[s] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      if (m_hs_w[k]) begin
        s_valid_d[tgt_w[k]] = 1'b1;
        s_resp_d[tgt_w[k]]  = m_bresp_w[k];
      end
    end
    // Hand priority to the loser only after a contended grant completes
    if (contend_w && (m_hs_w != 2'b00)) rr_d[tgt_w[0]] = ~rr_q[tgt_w[0]];
  end

  // S response registers and round-robin pointers, cleared asynchronously
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s_valid_q <= '0;
      s_resp_q  <= '{default: 2'b00};
      rr_q      <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_resp_q  <= s_resp_d;
      rr_q      <= rr_d;
    end
  end

endmodule
`default_nettype wire
